// File: rtl/div_pkg.sv
// Shared definitions for the divider result BCD converter: state encoding,
// default sizing, the double-dabble add-3 threshold and 7-segment decode.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_DIGITS = 2;

    // Digits at or above this value get +3 before each shift.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Segment pattern for 'E' (bits g..a), shown on every digit for an error.
    localparam logic [6:0] SEG_E = 7'b1111001;

    // Active-high segments, bit 0 = a ... bit 6 = g; non-decimal codes blank.
    function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import div_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/div_result_bcd.sv
// Captures a divider result (or divide-by-zero report), converts quotient and
// remainder to packed BCD with a sequential shift-add-3 engine and holds the
// result on a valid/ready interface. Completions arriving while a conversion
// or an unaccepted result is pending are dropped and flagged in overrun.
// Optional macro DIV_RESULT_BCD_SEG_EN adds registered 7-segment outputs.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done,
    input  logic                  error,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err_flag,
    output logic                  busy,
    output logic                  overrun
`ifdef DIV_RESULT_BCD_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   q_seg,
    output logic [7*DIGITS-1:0]   r_seg
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic            done_dly_q, error_dly_q;
    logic            trig_s;
    logic            capture_s;
    logic [WIDTH-1:0] q_bin_q, q_bin_d, r_bin_q, r_bin_d;
    logic [BW-1:0]   q_acc_q, q_acc_d, r_acc_q, r_acc_d;
    logic [BW-1:0]   q_adj_s, r_adj_s;
    logic [SW-1:0]   q_shift_s, r_shift_s;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic            err_q, err_d;
    logic            overrun_q, overrun_d;
    logic            valid_q, busy_q;

    // A completion counts once, on the first cycle either level is seen high.
    assign trig_s = (done | error) & ~(done_dly_q | error_dly_q);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_q_adj (
                .digit_i (q_acc_q[4*g +: 4]),
                .digit_o (q_adj_s[4*g +: 4])
            );
            bcd_digit_adj u_r_adj (
                .digit_i (r_acc_q[4*g +: 4]),
                .digit_o (r_adj_s[4*g +: 4])
            );
        end
    endgenerate

    // One double-dabble step: corrected digits and binary shift left together.
    assign q_shift_s = {q_adj_s, q_bin_q} << 1;
    assign r_shift_s = {r_adj_s, r_bin_q} << 1;

    // Next-state logic: conversion stepping, handshake and capture decisions.
    always_comb begin
        state_d   = state_q;
        q_bin_d   = q_bin_q;
        r_bin_d   = r_bin_q;
        q_acc_d   = q_acc_q;
        r_acc_d   = r_acc_q;
        count_d   = count_q;
        q_bcd_d   = q_bcd_q;
        r_bcd_d   = r_bcd_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        capture_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_s) begin
                    capture_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                q_bin_d = q_shift_s[WIDTH-1:0];
                r_bin_d = r_shift_s[WIDTH-1:0];
                q_acc_d = q_shift_s[SW-1:WIDTH];
                r_acc_d = r_shift_s[SW-1:WIDTH];
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    state_d = HOLD;
                    q_bcd_d = q_shift_s[SW-1:WIDTH];
                    r_bcd_d = r_shift_s[SW-1:WIDTH];
                    err_d   = 1'b0;
                end else begin
                    state_d = CONVERT;
                end
                if (trig_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Transfer; a simultaneous new completion is taken without a bubble.
                    if (trig_s) begin
                        capture_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trig_s) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_s) begin
            if (error) begin
                state_d = HOLD;
                err_d   = 1'b1;
                q_bcd_d = '0;
                r_bcd_d = '0;
            end else begin
                state_d = CONVERT;
                q_bin_d = quotient;
                r_bin_d = remainder;
                q_acc_d = '0;
                r_acc_d = '0;
                count_d = '0;
            end
        end else begin
            count_d = count_d;
        end
    end

    // State, datapath and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_dly_q  <= 1'b0;
            error_dly_q <= 1'b0;
            q_bin_q     <= '0;
            r_bin_q     <= '0;
            q_acc_q     <= '0;
            r_acc_q     <= '0;
            count_q     <= '0;
            q_bcd_q     <= '0;
            r_bcd_q     <= '0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_dly_q  <= done;
            error_dly_q <= error;
            q_bin_q     <= q_bin_d;
            r_bin_q     <= r_bin_d;
            q_acc_q     <= q_acc_d;
            r_acc_q     <= r_acc_d;
            count_q     <= count_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            valid_q     <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign out_valid = valid_q;
    assign q_bcd     = q_bcd_q;
    assign r_bcd     = r_bcd_q;
    assign err_flag  = err_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

`ifdef DIV_RESULT_BCD_SEG_EN
    logic [7*DIGITS-1:0] q_seg_q, q_seg_d, r_seg_q, r_seg_d;

    // Segment decode of the next BCD value, or 'E' on every digit for errors.
    always_comb begin
        q_seg_d = '0;
        r_seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (err_d) begin
                q_seg_d[7*i +: 7] = SEG_E;
                r_seg_d[7*i +: 7] = SEG_E;
            end else begin
                q_seg_d[7*i +: 7] = seg7_digit(q_bcd_d[4*i +: 4]);
                r_seg_d[7*i +: 7] = seg7_digit(r_bcd_d[4*i +: 4]);
            end
        end
    end

    // Segment registers track the BCD registers cycle for cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_seg_q <= '0;
            r_seg_q <= '0;
        end else begin
            q_seg_q <= q_seg_d;
            r_seg_q <= r_seg_d;
        end
    end

    assign q_seg = q_seg_q;
    assign r_seg = r_seg_q;
`endif

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Downstream consumer of the 4-bit iterative divider.
- Captures quotient/remainder (or the divide-by-zero error) when the divider completes, converts both to packed BCD with a sequential shift-add-3 (double-dabble) engine, and presents the result on a valid/ready output for display or logging logic.
- One conversion in flight; results arriving while busy are flagged, not queued.

Parameters:
- WIDTH, 4, width of the divider's quotient/remainder inputs.
- DIGITS, 2, BCD digits per value; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- done  in  1  divider completion, level (held high while result stable)
- error  in  1  divider divide-by-zero flag, level
- quotient  in  WIDTH  divider quotient
- remainder  in  WIDTH  divider remainder
- out_ready  in  1  downstream accepts result
- out_valid  out  1  result held and valid
- q_bcd  out  4*DIGITS  packed BCD quotient, digit 0 in [3:0]
- r_bcd  out  4*DIGITS  packed BCD remainder
- err_flag  out  1  result is a divide-by-zero report
- busy  out  1  state != IDLE
- overrun  out  1  sticky: a completion was dropped

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all outputs 0; done_d/error_d=0; overrun cleared. Reset wins over any other event, including mid-conversion or during HOLD.
- Trigger: trig = (done|error) & ~(done_d|error_d). done_d/error_d are registered every cycle. A level held high triggers only once.
- IDLE:
  - trig with error=1: load err_flag=1, q_bcd=r_bcd=0, go to HOLD. out_valid rises one cycle after the trigger edge.
  - trig with error=0: latch quotient/remainder into shift registers, clear BCD accumulators, count=0, go to CONVERT.
- CONVERT:
  - Each edge, every BCD digit >=5 gets +3, then {bcd,bin} shifts left 1. Quotient and remainder are processed in parallel.
  - count increments; after WIDTH shifts (the edge where count==WIDTH-1) go to HOLD and load q_bcd/r_bcd.
  - out_valid is high exactly WIDTH cycles after the capture edge (4 for default).
- HOLD:
  - out_valid=1; q_bcd, r_bcd and err_flag are stable until transfer.
  - Transfer occurs at the edge with out_valid & out_ready. Go to IDLE and drop out_valid, unless trig is also high that cycle, in which case capture directly (CONVERT or error HOLD) with no bubble.
- trig in CONVERT, or in HOLD without transfer: input ignored, overrun<=1 (sticky until rst).
- Outputs are registered; no combinational path from inputs to outputs.
- count width is clog2(WIDTH)+1; no wrap occurs within a conversion.

Optional Feature:
- Macro DIV_RESULT_BCD_SEG_EN.
- Defined: adds outputs q_seg and r_seg, each 7*DIGITS wide, active-high segments a..g in bits [6:0] per digit. They are registered and updated with q_bcd/r_bcd. When err_flag=1, every digit shows 'E' (7'b1111001).
- Undefined: ports and decode logic are absent; all other behaviour is identical.

Decomposition:
- Shared package div_pkg:
  - state encoding IDLE/CONVERT/HOLD
  - default WIDTH/DIGITS
  - add-3 threshold constant (5)
  - 7-segment digit lookup function and 'E' constant
- Sub-module bcd_digit_adj: 4-bit combinational digit in, digit+3 if >=5 out. Instantiated 2*DIGITS times.
- FSM, shift registers and handshake live in the top module.

Test Plan:
- quotient=13, remainder=2, done rises, out_ready=1 -> out_valid high 4 cycles after capture; q_bcd=8'h13, r_bcd=8'h02, err_flag=0; back to IDLE next edge.
- quotient=15, remainder=0 -> q_bcd=8'h15, r_bcd=8'h00. Also sweep all 16x16 input pairs against a reference model.
- error=1, done=0 rising -> out_valid one cycle later, err_flag=1, q_bcd=r_bcd=0. With DIV_RESULT_BCD_SEG_EN, segments read 'E','E'.
- out_ready=0 for 10 cycles in HOLD, then a new done edge -> outputs unchanged, overrun=1. The same edge coinciding with out_ready=1 captures the new value, overrun stays 0 in a fresh run.
- done held high 20 cycles -> exactly one conversion.
- rst asserted on the 2nd CONVERT cycle -> next cycle busy=0, out_valid=0, all outputs 0.
